// File: rtl/cpu1_jtag_debug_scan_host.sv
// cpu1_jtag_debug_scan_host: host-side virtual-JTAG scan initiator for the CPU1 debug module.
//   clk, reset (async, active-high)
//   cmd_valid/cmd_ready/cmd_ir/cmd_data : one command in (IR + DR word, LSB shifted first)
//   resp_valid/resp_data/resp_ir        : one-cycle response pulse with captured DR and IR status
//   vji_*                               : generated tck, tdi, ir_in and uir/cdr/sdr/udr/rti strobes
module cpu1_jtag_debug_scan_host #(
    parameter int DR_WIDTH = 38,
    parameter int TCK_HALF = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                resp_valid,
    output logic [DR_WIDTH-1:0] resp_data,
    output logic [1:0]          resp_ir,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [1:0]          vji_ir_in,
    input  logic [1:0]          vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);
    localparam int PW = $clog2(2*TCK_HALF+1);
    localparam int CW = $clog2(DR_WIDTH+1);
    localparam logic [PW-1:0] PH_LAST = PW'(2*TCK_HALF-1);
    localparam logic [PW-1:0] PH_RISE = PW'(TCK_HALF-1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DR_WIDTH-1);

    typedef enum logic [2:0] {S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI} state_t;

    state_t              r_state, w_state_nxt;
    logic [PW-1:0]       r_ph;
    logic [PW-1:0]       w_ph_nxt;
    logic [CW-1:0]       r_cnt;
    logic [DR_WIDTH-1:0] r_shift;
    logic [DR_WIDTH-1:0] r_resp_data;
    logic [1:0]          r_resp_ir;
    logic [1:0]          r_ir_in;
    logic                r_resp_valid;
    logic                r_tck;
    logic                r_tdi;
    logic                w_accept;
    logic                w_step_end;
    logic                w_rise;

    assign w_accept   = cmd_valid && (r_state == S_IDLE);
    assign w_step_end = (r_state != S_IDLE) && (r_ph == PH_LAST);
    // the edge that takes tck high is the one that samples tdo / ir_out
    assign w_rise     = (r_state != S_IDLE) && (r_ph == PH_RISE);
    assign w_ph_nxt   = (r_state == S_IDLE || w_step_end) ? '0 : r_ph + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = w_accept ? S_UIR : S_IDLE;
            S_UIR:   w_state_nxt = w_step_end ? S_CDR : S_UIR;
            S_CDR:   w_state_nxt = w_step_end ? S_SDR : S_CDR;
            S_SDR:   w_state_nxt = (w_step_end && r_cnt == CNT_LAST) ? S_UDR : S_SDR;
            S_UDR:   w_state_nxt = w_step_end ? S_RTI : S_UDR;
            S_RTI:   w_state_nxt = w_step_end ? S_IDLE : S_RTI;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ph         <= '0;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_resp_data  <= '0;
            r_resp_ir    <= '0;
            r_ir_in      <= '0;
            r_resp_valid <= 1'b0;
            r_tck        <= 1'b0;
            r_tdi        <= 1'b0;
        end else begin
            r_ph         <= w_ph_nxt;
            r_tck        <= (w_state_nxt != S_IDLE) && (w_ph_nxt >= PW'(TCK_HALF));
            r_resp_valid <= (r_state == S_RTI) && w_step_end;
            if (r_state == S_SDR && w_step_end) r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
            if (w_accept) begin
                r_shift <= cmd_data;
                r_ir_in <= cmd_ir;
            end else if (w_rise && r_state == S_SDR) begin
                // {tdo, shift[W-1:1]} written so that DR_WIDTH=1 needs no special case
                r_shift <= DR_WIDTH'({vji_tdo, r_shift} >> 1);
            end
            if (w_rise && r_state == S_UIR) r_resp_ir <= vji_ir_out;
            if (r_state == S_RTI && w_step_end) r_resp_data <= r_shift;
            // tdi moves only at step boundaries; the shift already advanced at this step's rise
            if (w_step_end) r_tdi <= (w_state_nxt == S_SDR) && r_shift[0];
        end
    end

    assign cmd_ready  = (r_state == S_IDLE);
    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_ir    = r_resp_ir;
    assign vji_tck    = r_tck;
    assign vji_tdi    = r_tdi;
    assign vji_ir_in  = r_ir_in;
    assign vji_uir    = (r_state == S_UIR);
    assign vji_cdr    = (r_state == S_CDR);
    assign vji_sdr    = (r_state == S_SDR);
    assign vji_udr    = (r_state == S_UDR);
    assign vji_rti    = (r_state == S_RTI);
endmodule

// File: tb/tb_cpu1_jtag_debug_scan_host.sv
// tb_cpu1_jtag_debug_scan_host: self-checking bench for the virtual-JTAG scan host.
module tb_cpu1_jtag_debug_scan_host;
    localparam int W = 38;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;

    // default instance (TCK_HALF=1)
    logic         d_valid = 1'b0;
    logic [1:0]   d_ir = '0;
    logic [W-1:0] d_data = '0;
    logic         d_ready, d_rv;
    logic [W-1:0] d_rdata;
    logic [1:0]   d_rir;
    logic         d_tck, d_tdi, d_tdo;
    logic [1:0]   d_irin;
    logic [1:0]   d_irout = '0;
    logic         d_uir, d_cdr, d_sdr, d_udr, d_rti;
    logic         d_lb = 1'b1;
    logic [W-1:0] tdo_pat = '0;

    // slow instance (TCK_HALF=3), tdo looped back
    logic         s_valid = 1'b0;
    logic [1:0]   s_ir = '0;
    logic [W-1:0] s_data = '0;
    logic         s_ready, s_rv;
    logic [W-1:0] s_rdata;
    logic [1:0]   s_rir;
    logic         s_tck, s_tdi;
    logic [1:0]   s_irin;
    logic         s_uir, s_cdr, s_sdr, s_udr, s_rti;

    int n_rise, n_uir, n_cdr, n_sdr, n_udr, n_rti, n_bad, n_rv, n_acc;
    logic tdi_q[$];

    // tdo either echoes tdi or plays a bench-chosen pattern, bit i on the i-th sdr rise
    assign d_tdo = d_lb ? d_tdi : tdo_pat[(n_sdr < W) ? n_sdr : W-1];

    cpu1_jtag_debug_scan_host #(.DR_WIDTH(W), .TCK_HALF(1)) u_dut (
        .clk(clk), .reset(reset), .cmd_valid(d_valid), .cmd_ready(d_ready), .cmd_ir(d_ir),
        .cmd_data(d_data), .resp_valid(d_rv), .resp_data(d_rdata), .resp_ir(d_rir),
        .vji_tck(d_tck), .vji_tdi(d_tdi), .vji_tdo(d_tdo), .vji_ir_in(d_irin),
        .vji_ir_out(d_irout), .vji_uir(d_uir), .vji_cdr(d_cdr), .vji_sdr(d_sdr),
        .vji_udr(d_udr), .vji_rti(d_rti)
    );

    cpu1_jtag_debug_scan_host #(.DR_WIDTH(W), .TCK_HALF(3)) u_slow (
        .clk(clk), .reset(reset), .cmd_valid(s_valid), .cmd_ready(s_ready), .cmd_ir(s_ir),
        .cmd_data(s_data), .resp_valid(s_rv), .resp_data(s_rdata), .resp_ir(s_rir),
        .vji_tck(s_tck), .vji_tdi(s_tdi), .vji_tdo(s_tdi), .vji_ir_in(s_irin),
        .vji_ir_out(2'b11), .vji_uir(s_uir), .vji_cdr(s_cdr), .vji_sdr(s_sdr),
        .vji_udr(s_udr), .vji_rti(s_rti)
    );

    always @(posedge d_tck) begin
        n_rise++;
        if (d_uir) n_uir++;
        if (d_cdr) n_cdr++;
        if (d_udr) n_udr++;
        if (d_rti) n_rti++;
        if ($countones({d_uir, d_cdr, d_sdr, d_udr, d_rti}) != 1) n_bad++;
        if (d_sdr) begin
            tdi_q.push_back(d_tdi);
            n_sdr++;
        end
    end

    always @(posedge clk) begin
        if (d_rv) n_rv++;
        if (s_valid && s_ready) n_acc++;
    end

    task automatic clear_mon();
        n_rise = 0; n_uir = 0; n_cdr = 0; n_sdr = 0; n_udr = 0; n_rti = 0; n_bad = 0;
        tdi_q.delete();
    endtask

    // issues one command on the default instance; lat = edges from accept to resp_valid
    task automatic send_d(input logic [1:0] ir, input logic [W-1:0] data, output int lat);
        int k;
        k = 0;
        while (!d_ready && k < 500) begin @(posedge clk); #1; k++; end
        clear_mon();
        d_valid = 1'b1; d_ir = ir; d_data = data;
        @(posedge clk); #1;
        d_valid = 1'b0;
        lat = 0;
        while (!d_rv && lat < 1000) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (d_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_during got=%b exp=1", d_ready); end
        n_tests++;
        if ({d_tck, d_tdi, d_uir, d_cdr, d_sdr, d_udr, d_rti, d_irin, d_rv, d_rdata, d_rir} !== '0) begin
            n_fail++; $display("FAIL reset_outputs got=%h exp=0", {d_tck, d_tdi, d_uir, d_cdr, d_sdr, d_udr, d_rti, d_irin, d_rv, d_rdata, d_rir});
        end
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (d_ready !== 1'b1 || s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after got=%b%b exp=11", d_ready, s_ready); end
    endtask

    task automatic test_loopback();
        int lat;
        logic [W-1:0] data;
        data = 38'h15_A5A5_5A5A;
        d_lb = 1'b1;
        send_d(2'b10, data, lat);
        n_tests++;
        if (lat != 84) begin n_fail++; $display("FAIL loop_latency got=%0d exp=84", lat); end
        n_tests++;
        if (d_rdata !== data) begin n_fail++; $display("FAIL loop_data got=%h exp=%h", d_rdata, data); end
        n_tests++;
        if (n_rise != 42) begin n_fail++; $display("FAIL loop_tck_rises got=%0d exp=42", n_rise); end
        n_tests++;
        if (d_irin !== 2'b10) begin n_fail++; $display("FAIL loop_ir_in got=%b exp=10", d_irin); end
        n_tests++;
        if (d_ready !== 1'b1) begin n_fail++; $display("FAIL loop_ready_with_valid got=%b exp=1", d_ready); end
        @(posedge clk); #1;
        n_tests++;
        if (d_rv !== 1'b0 || d_rdata !== data) begin n_fail++; $display("FAIL loop_pulse_hold rv=%b data=%h exp rv=0 data=%h", d_rv, d_rdata, data); end
    endtask

    task automatic test_const();
        int lat;
        d_lb = 1'b0; tdo_pat = '1; d_irout = 2'b01;
        send_d(2'b00, W'({$urandom(), $urandom()}), lat);
        n_tests++;
        if (d_rdata !== 38'h3F_FFFF_FFFF) begin n_fail++; $display("FAIL const_data got=%h exp=3fffffffff", d_rdata); end
        n_tests++;
        if (d_rir !== 2'b01) begin n_fail++; $display("FAIL const_ir got=%b exp=01", d_rir); end
        d_lb = 1'b1; d_irout = 2'b00;
    endtask

    task automatic test_strobes();
        int lat;
        logic [W-1:0] data, seen;
        data = W'({$urandom(), $urandom()});
        d_lb = 1'b1;
        send_d(2'b11, data, lat);
        n_tests++;
        if ({n_uir, n_cdr, n_sdr, n_udr, n_rti} != {32'd1, 32'd1, 32'd38, 32'd1, 32'd1}) begin
            n_fail++; $display("FAIL strobe_counts got uir=%0d cdr=%0d sdr=%0d udr=%0d rti=%0d exp 1 1 38 1 1", n_uir, n_cdr, n_sdr, n_udr, n_rti);
        end
        n_tests++;
        if (n_bad != 0) begin n_fail++; $display("FAIL strobe_onehot got=%0d exp=0 violations", n_bad); end
        seen = '0;
        for (int i = 0; i < W && i < tdi_q.size(); i++) seen[i] = tdi_q[i];
        n_tests++;
        if (tdi_q.size() != W || seen !== data) begin n_fail++; $display("FAIL strobe_tdi_order got=%h (%0d bits) exp=%h", seen, tdi_q.size(), data); end
        n_tests++;
        if ({d_tck, d_tdi, d_uir, d_cdr, d_sdr, d_udr, d_rti} !== '0) begin n_fail++; $display("FAIL idle_signals got=%b exp=0", {d_tck, d_tdi, d_uir, d_cdr, d_sdr, d_udr, d_rti}); end
    endtask

    task automatic test_random();
        int lat;
        logic [1:0] ir;
        logic [W-1:0] data, exp_d;
        for (int it = 0; it < 8; it++) begin
            ir = 2'($urandom());
            data = W'({$urandom(), $urandom()});
            d_irout = 2'($urandom());
            d_lb = 1'($urandom());
            tdo_pat = W'({$urandom(), $urandom()});
            exp_d = d_lb ? data : tdo_pat;
            send_d(ir, data, lat);
            n_tests++;
            if (d_rdata !== exp_d || d_rir !== d_irout || d_irin !== ir || lat != 84 || n_rise != 42) begin
                n_fail++;
                $display("FAIL random_%0d data=%h/%h ir=%b/%b ir_in=%b/%b lat=%0d/84 rises=%0d/42", it, d_rdata, exp_d, d_rir, d_irout, d_irin, ir, lat, n_rise);
            end
        end
        d_lb = 1'b1;
    endtask

    task automatic test_back_to_back();
        int lat, k;
        logic [W-1:0] a, b;
        a = W'({$urandom(), $urandom()});
        b = W'({$urandom(), $urandom()});
        n_acc = 0;
        s_valid = 1'b1; s_ir = 2'b01; s_data = a;
        @(posedge clk); #1;
        lat = 0;
        while (!s_rv && lat < 2000) begin @(posedge clk); #1; lat++; end
        n_tests++;
        if (lat != 252) begin n_fail++; $display("FAIL b2b_latency1 got=%0d exp=252", lat); end
        n_tests++;
        if (s_rdata !== a || s_rir !== 2'b11) begin n_fail++; $display("FAIL b2b_data1 got=%h/%b exp=%h/11", s_rdata, s_rir, a); end
        s_data = b; s_ir = 2'b10;
        k = 0;
        do begin @(posedge clk); #1; k++; end while (!s_rv && k < 2000);
        s_valid = 1'b0;
        n_tests++;
        if (k != 253) begin n_fail++; $display("FAIL b2b_latency2 got=%0d exp=253 from first resp", k); end
        n_tests++;
        if (s_rdata !== b || s_irin !== 2'b10) begin n_fail++; $display("FAIL b2b_data2 got=%h/%b exp=%h/10", s_rdata, s_irin, b); end
        @(posedge clk); #1;
        n_tests++;
        if (n_acc != 2) begin n_fail++; $display("FAIL b2b_accepts got=%0d exp=2", n_acc); end
    endtask

    task automatic test_reset_mid();
        int k, lat;
        logic [W-1:0] data;
        data = W'({$urandom(), $urandom()});
        d_lb = 1'b1;
        clear_mon();
        d_valid = 1'b1; d_ir = 2'b11; d_data = data;
        @(posedge clk); #1;
        d_valid = 1'b0;
        k = 0;
        while (n_sdr < 10 && k < 500) begin @(posedge clk); #1; k++; end
        n_tests++;
        if (n_sdr != 10) begin n_fail++; $display("FAIL mid_reach_sdr10 got=%0d exp=10", n_sdr); end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({d_tck, d_tdi, d_uir, d_cdr, d_sdr, d_udr, d_rti, d_irin, d_rv, d_rdata, d_rir} !== '0 || d_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_reset_outputs got=%h ready=%b exp=0 ready=1", {d_tck, d_tdi, d_uir, d_cdr, d_sdr, d_udr, d_rti, d_irin, d_rv, d_rdata, d_rir}, d_ready);
        end
        n_rv = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        n_tests++;
        if (n_rv != 0 || d_ready !== 1'b1) begin n_fail++; $display("FAIL mid_no_resp got rv=%0d ready=%b exp rv=0 ready=1", n_rv, d_ready); end
        data = W'({$urandom(), $urandom()});
        send_d(2'b01, data, lat);
        n_tests++;
        if (d_rdata !== data || lat != 84 || n_rise != 42) begin n_fail++; $display("FAIL mid_recover data=%h/%h lat=%0d/84 rises=%0d/42", d_rdata, data, lat, n_rise); end
    endtask

    initial begin
        clear_mon();
        n_rv = 0; n_acc = 0;
        test_reset();
        test_loopback();
        test_const();
        test_strobes();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
